// File: rtl/risc_cpu_top.sv
// VeriRISC-style 8-bit accumulator CPU: PC, IR, AC, ALU, unified 32x8 memory
// and an 8-phase sequencing controller. Every instruction takes 8 clocks.

package risc_pkg;
   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7
   } phase_t;
endpackage

module risc_memory #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rd,
   input  logic              wr,
   input  logic [AWIDTH-1:0] addr,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] rdata
);
   logic [DWIDTH-1:0] array [0:2**AWIDTH-1];

   // NOTE: storage deliberately has no reset so the program survives a CPU reset.
   always_ff @(posedge clk) begin
      if (wr) array[addr] <= wdata;
   end

   assign rdata = rd ? array[addr] : '0;
endmodule

module risc_controller
   import risc_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  opcode_t opcode,
   input  logic    zero,
   output logic    sel,
   output logic    rd,
   output logic    ld_ir,
   output logic    inc_pc,
   output logic    halt,
   output logic    ld_pc,
   output logic    data_e,
   output logic    ld_ac,
   output logic    wr
);
   phase_t phase, phase_next;
   logic   alu_op;

   // NOTE: sequential state uses non-blocking assignments; combinational logic uses blocking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) phase <= PH0;
      else      phase <= phase_next;
   end

   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      alu_op = opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
      case (phase)
         PH0: sel = 1'b1;
         PH1: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         PH2, PH3: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         PH4: begin
            inc_pc = 1'b1;
            halt   = (opcode == OP_HLT);
         end
         PH5: rd = alu_op;
         PH6: begin
            rd     = alu_op;
            inc_pc = (opcode == OP_SKZ) && zero;
            ld_pc  = (opcode == OP_JMP);
            data_e = (opcode == OP_STO);
         end
         PH7: begin
            rd     = alu_op;
            ld_ac  = alu_op;
            inc_pc = (opcode == OP_JMP);
            ld_pc  = (opcode == OP_JMP);
            wr     = (opcode == OP_STO);
            data_e = (opcode == OP_STO);
         end
      endcase
      // Freezing the sequencer on HLT keeps halt asserted until reset.
      phase_next = halt ? phase : phase_t'(phase + 3'd1);
   end
endmodule

module risc_cpu_top
   import risc_pkg::*;
#(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   output logic halt
);
   logic [AWIDTH-1:0] pc_addr, ir_addr, mem_addr;
   logic [DWIDTH-1:0] ir, ac, alu_out, mem_rdata, data_bus;
   opcode_t           opcode;
   logic              zero;
   logic              sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr;

   assign ir_addr  = ir[AWIDTH-1:0];
   assign opcode   = opcode_t'(ir[DWIDTH-1:AWIDTH]);
   assign zero     = (ac == '0);
   assign mem_addr = sel ? pc_addr : ir_addr;
   assign data_bus = data_e ? ac : mem_rdata;

   risc_memory #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) memory_inst (
      .clk   (clk),
      .rd    (rd),
      .wr    (wr),
      .addr  (mem_addr),
      .wdata (data_bus),
      .rdata (mem_rdata)
   );

   risc_controller controller_inst (
      .clk    (clk),
      .rst    (rst),
      .opcode (opcode),
      .zero   (zero),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .halt   (halt),
      .ld_pc  (ld_pc),
      .data_e (data_e),
      .ld_ac  (ld_ac),
      .wr     (wr)
   );

   // A jump load wins over the increment in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        pc_addr <= '0;
      else if (ld_pc)  pc_addr <= ir_addr;
      else if (inc_pc) pc_addr <= pc_addr + AWIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       ir <= '0;
      else if (ld_ir) ir <= data_bus;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       ac <= '0;
      else if (ld_ac) ac <= alu_out;
   end

   always_comb begin
      case (opcode)
         OP_ADD:  alu_out = ac + data_bus;
         OP_AND:  alu_out = ac & data_bus;
         OP_XOR:  alu_out = ac ^ data_bus;
         OP_LDA:  alu_out = data_bus;
         default: alu_out = ac;
      endcase
   end
endmodule

// File: tb/tb_risc_cpu_top.sv
// Directed program-level bench for risc_cpu_top: each vector preloads a program,
// checks the exact halt edge, final PC/AC and one memory word.

module tb_risc_cpu_top;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic halt;
   int   checks = 0;
   int   errors = 0;

   risc_cpu_top dut (
      .clk  (clk),
      .rst  (rst),
      .halt (halt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      int         prog;
      int         halt_edge;
      logic [4:0] exp_pc;
      logic [7:0] exp_ac;
      logic [4:0] mem_addr;
      logic [7:0] mem_val;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load_prog(input int id);
      for (int i = 0; i < 32; i++) dut.memory_inst.array[i] = 8'h00;
      case (id)
         0: dut.memory_inst.array[0] = 8'h00;                  // HLT
         1: begin                                              // JMP
            dut.memory_inst.array[0] = 8'hE2;
            dut.memory_inst.array[1] = 8'h00;
            dut.memory_inst.array[2] = 8'h00;
         end
         2: begin                                              // SKZ with AC=0
            dut.memory_inst.array[0] = 8'h20;
            dut.memory_inst.array[1] = 8'hE2;
            dut.memory_inst.array[2] = 8'h00;
         end
         3: begin                                              // LDA/STO
            dut.memory_inst.array[0] = 8'hA7;
            dut.memory_inst.array[1] = 8'hC8;
            dut.memory_inst.array[2] = 8'hA8;
            dut.memory_inst.array[3] = 8'h20;
            dut.memory_inst.array[4] = 8'h00;
            dut.memory_inst.array[5] = 8'hE6;
            dut.memory_inst.array[6] = 8'h00;
            dut.memory_inst.array[7] = 8'h01;
            dut.memory_inst.array[8] = 8'h00;
         end
         4: begin                                              // ADD wrap
            dut.memory_inst.array[0]  = 8'hAA;
            dut.memory_inst.array[1]  = 8'h4B;
            dut.memory_inst.array[2]  = 8'h20;
            dut.memory_inst.array[3]  = 8'h00;
            dut.memory_inst.array[4]  = 8'h4B;
            dut.memory_inst.array[5]  = 8'h20;
            dut.memory_inst.array[6]  = 8'h00;
            dut.memory_inst.array[10] = 8'hFF;
            dut.memory_inst.array[11] = 8'h01;
         end
         5, 6: begin                                           // AND (5) / XOR (6)
            dut.memory_inst.array[0] = 8'hB0;
            dut.memory_inst.array[1] = (id == 5) ? 8'h71 : 8'h91;
            dut.memory_inst.array[2] = 8'h20;
            dut.memory_inst.array[3] = (id == 5) ? 8'h72 : 8'h92;
            dut.memory_inst.array[4] = 8'h20;
            dut.memory_inst.array[5] = 8'h00;
            dut.memory_inst.array[6] = (id == 5) ? 8'hB1 : 8'hB2;
            dut.memory_inst.array[7] = 8'h20;
            dut.memory_inst.array[8] = 8'h00;
            dut.memory_inst.array[16] = (id == 5) ? 8'hFF : 8'h55;
            dut.memory_inst.array[17] = (id == 5) ? 8'h01 : 8'h54;
            dut.memory_inst.array[18] = (id == 5) ? 8'hFE : 8'h01;
         end
         default: ;
      endcase
   endtask

   // Reset held across a negedge while loading; release lands mid-cycle so the
   // next rising edge is edge 1.
   task automatic reset_and_load(input int id);
      rst = 1'b0;
      @(negedge clk);
      load_prog(id);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{"hlt",     0,  4, 5'd0, 8'h00, 5'd0,  8'h00};
      vecs[1] = '{"jmp",     1, 12, 5'd2, 8'h00, 5'd0,  8'hE2};
      vecs[2] = '{"skz",     2, 12, 5'd2, 8'h00, 5'd1,  8'hE2};
      vecs[3] = '{"lda_sto", 3, 36, 5'd4, 8'h01, 5'd8,  8'h01};
      vecs[4] = '{"add",     4, 44, 5'd6, 8'h01, 5'd10, 8'hFF};
      vecs[5] = '{"and",     5, 60, 5'd8, 8'h01, 5'd18, 8'hFE};
      vecs[6] = '{"xor",     6, 60, 5'd8, 8'h01, 5'd17, 8'h54};

      // Reset state, then one clock after release.
      rst = 1'b0;
      #1;
      check("rst_phase", 32'(dut.controller_inst.phase), 32'd0);
      check("rst_pc",    32'(dut.pc_addr), 32'd0);
      check("rst_ir",    32'(dut.ir), 32'd0);
      check("rst_ac",    32'(dut.ac), 32'd0);
      reset_and_load(0);
      run(1);
      check("rst_halt_1clk", 32'(halt), 32'd0);
      check("rst_phase_1clk", 32'(dut.controller_inst.phase), 32'd1);

      for (int v = 0; v < 7; v++) begin
         reset_and_load(vecs[v].prog);
         run(vecs[v].halt_edge - 1);
         check({vecs[v].name, "_halt_early"}, 32'(halt), 32'd0);
         run(1);
         check({vecs[v].name, "_halt"}, 32'(halt), 32'd1);
         check({vecs[v].name, "_pc"}, 32'(dut.pc_addr), 32'(vecs[v].exp_pc));
         check({vecs[v].name, "_ac"}, 32'(dut.ac), 32'(vecs[v].exp_ac));
         run(5);
         check({vecs[v].name, "_halt_held"}, 32'(halt), 32'd1);
         check({vecs[v].name, "_mem"}, 32'(dut.memory_inst.array[vecs[v].mem_addr]),
               32'(vecs[v].mem_val));
      end

      // Asynchronous reset in phase 5 of the STO instruction, away from any edge.
      reset_and_load(3);
      run(13);
      check("mid_phase_pre", 32'(dut.controller_inst.phase), 32'd5);
      check("mid_ac_pre",    32'(dut.ac), 32'd1);
      check("mid_ir_pre",    32'(dut.ir), 32'hC8);
      #1;
      rst = 1'b0;
      #1;
      check("mid_phase", 32'(dut.controller_inst.phase), 32'd0);
      check("mid_pc",    32'(dut.pc_addr), 32'd0);
      check("mid_ir",    32'(dut.ir), 32'd0);
      check("mid_ac",    32'(dut.ac), 32'd0);
      check("mid_mem8",  32'(dut.memory_inst.array[8]), 32'd0);
      reset_and_load(0);
      run(3);
      check("mid_halt_early", 32'(halt), 32'd0);
      run(1);
      check("mid_halt", 32'(halt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/risc_cpu_top.md
Name: risc_cpu_top

Overview:
- Top level of an 8-bit accumulator RISC CPU (VeriRISC style).
- Contains a 5-bit program counter, an 8-bit instruction register, an 8-bit accumulator and an ALU.
- Also contains a 32x8 unified instruction/data memory and an 8-phase sequencing controller.
- Each instruction takes exactly 8 clocks. The only external output is the halt flag.

Parameters:
- AWIDTH, 5, address width; memory depth is 2**AWIDTH = 32.
- DWIDTH, 8, data/instruction width; opcode is bits [7:5], operand address is bits [4:0].

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- halt  output  1  high while a HLT instruction is in its execute phases.

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Reset (asynchronous) clears phase counter, PC, IR and AC to 0. Memory contents are not altered. This applies equally when reset occurs mid-instruction.
- The bench preloads memory hierarchically, so the following names are required:
  - memory instance memory_inst, with storage array[0:31];
  - controller instance controller_inst, with signals inc_pc, ld_pc, halt;
  - top-level nets pc_addr, ir_addr, zero.
- Phase counter: 3 bits, increments by 1 each clock and wraps 7->0. It is frozen while halt=1, so halt stays high until reset.
- Memory address mux: sel ? PC : IR[4:0].
- Memory read: combinational when rd=1.
- Memory write: at the rising edge when wr=1, storing AC at IR[4:0].
- Controller outputs are decoded combinationally from phase and IR[7:5]. ALUOP = ADD|AND|XOR|LDA.
  - phase 0: sel.
  - phase 1: sel, rd.
  - phase 2: sel, rd, ld_ir.
  - phase 3: sel, rd, ld_ir.
  - phase 4: inc_pc; halt = (op==HLT).
  - phase 5: rd = ALUOP.
  - phase 6: rd = ALUOP; inc_pc = (op==SKZ && zero); ld_pc = (op==JMP); data_e = (op==STO).
  - phase 7: rd = ALUOP; ld_ac = ALUOP; inc_pc = (op==JMP); ld_pc = (op==JMP); wr = (op==STO); data_e = (op==STO).
- PC update: ld_pc loads IR[4:0] and has priority over inc_pc. inc_pc adds 1, wrapping 31->0.
- IR update: loaded from the memory data bus when ld_ir=1.
- AC update: loaded from the ALU output when ld_ac=1.
- ALU result:
  - ADD: AC + data mod 256, carry discarded.
  - AND: AC & data.
  - XOR: AC ^ data.
  - LDA: data.
  - other opcodes: pass AC.
- zero = (AC == 0), combinational.
- Timing after reset release:
  - instruction k, phase p is active after rising edge 8k+p;
  - a HLT fetched as instruction k raises halt after edge 8k+4.
- SKZ with zero=1 gets two PC increments, skipping the next instruction. JMP target is IR[4:0].
- Undefined operand bits (x) in HLT/SKZ must not affect behaviour.

Test Plan:
- Reset: mem[0]=HLT; assert then release reset, 1 clock -> halt=0.
- HLT: mem[0]=HLT; 3 edges after release -> halt=0; 4th edge -> halt=1 and stays 1 for further clocks.
- JMP: mem[0]=JMP 2, mem[1]=HLT, mem[2]=HLT.
  - 11 edges -> halt=0; 12th -> halt=1; PC=2.
- SKZ with AC=0: mem[0]=SKZ, mem[1]=JMP 2, mem[2]=HLT.
  - 11 edges -> halt=0; 12th -> halt=1.
- LDA/STO: mem = LDA 7, STO 8, LDA 8, SKZ, HLT, JMP 6, HLT, [7]=1, [8]=0.
  - 35 edges -> halt=0; 36th -> halt=1; mem[8]=1 afterwards.
- ADD wrap plus AND/XOR:
  - ADD program: LDA 0xFF, ADD 0x01 (AC=0, SKZ skips), ADD 0x01, SKZ, HLT at addr 6 -> halt after edge 44, not at 43.
  - AND program: 0xFF & 0x01, then & 0xFE -> halt after edge 60, not at 59.
  - XOR program: 0x55 ^ 0x54, then ^ 0x01 -> halt after edge 60, not at 59.
- Async reset mid-instruction (phase 5): phase, PC, IR and AC read 0 immediately, before any clock edge; after release, a HLT program halts on edge 4.
